// File: rtl/tlc_mode_scheduler.sv
// Tail-light mode scheduler: synchronises and debounces the driver controls,
// then selects IDLE/LEFT/RIGHT/HAZARD and paces the light sequence with seq_tick.
module tlc_mode_scheduler #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TICK_DIV        = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       brake_pedal_in,
   input  logic       stalk_left_in,
   input  logic       stalk_right_in,
   input  logic       hazard_btn_in,
   output logic       brake,
   output logic       turn_left,
   output logic       turn_right,
   output logic       seq_tick,
   output logic [1:0] mode
);

   localparam int unsigned CW = 8;
   localparam int unsigned PW = 16;
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

   // Input lanes: 0 brake, 1 left stalk, 2 right stalk, 3 hazard button
   localparam int unsigned IB = 0;
   localparam int unsigned IL = 1;
   localparam int unsigned IR = 2;
   localparam int unsigned IH = 3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_LEFT   = 2'b01,
      S_RIGHT  = 2'b10,
      S_HAZARD = 2'b11
   } mode_t;

   logic [3:0]    w_raw;
   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [3:0]    r_deb;
   logic [CW-1:0] r_cnt [4];
   logic [3:0]    w_flip;
   logic [3:0]    w_deb_next;
   logic          r_hazard;
   logic          w_hazard_next;
   mode_t         r_mode;
   mode_t         w_target;
   mode_t         w_mode_next;
   logic          w_mode_chg;
   logic [PW-1:0] r_presc;

   assign w_raw = {hazard_btn_in, stalk_right_in, stalk_left_in, brake_pedal_in};

   // A lane flips on the edge that completes DEBOUNCE_CYCLES differing samples
   always_comb begin
      w_flip = '0;
      for (int i = 0; i < 4; i++) begin
         w_flip[i] = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == DB_LAST);
      end
      w_deb_next = r_deb ^ w_flip;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_deb   <= w_deb_next;
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_deb[i] || w_flip[i]) r_cnt[i] <= '0;
            else                                     r_cnt[i] <= r_cnt[i] + CW'(1);
         end
      end
   end

   assign w_hazard_next = r_hazard ^ (w_deb_next[IH] & ~r_deb[IH]);

   // Decisions use next-cycle debounced values so outputs land with the debounce edge
   always_comb begin
      w_target = S_IDLE;
      if (w_hazard_next) begin
         w_target = S_HAZARD;
      end else begin
         case ({w_deb_next[IR], w_deb_next[IL]})
            2'b01:   w_target = S_LEFT;
            2'b10:   w_target = S_RIGHT;
            default: w_target = S_IDLE;
         endcase
      end
      w_mode_next = w_target;
      if ((r_mode == S_LEFT && w_target == S_RIGHT) ||
          (r_mode == S_RIGHT && w_target == S_LEFT)) begin
         w_mode_next = S_IDLE;
      end
   end

   assign w_mode_chg = (w_mode_next != r_mode);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode     <= S_IDLE;
         r_hazard   <= 1'b0;
         brake      <= 1'b0;
         turn_left  <= 1'b0;
         turn_right <= 1'b0;
         r_presc    <= '0;
         seq_tick   <= 1'b0;
      end else begin
         r_mode     <= w_mode_next;
         r_hazard   <= w_hazard_next;
         brake      <= w_deb_next[IB];
         turn_left  <= w_mode_next[0];
         turn_right <= w_mode_next[1];
         if (w_mode_chg || w_mode_next == S_IDLE) begin
            r_presc  <= '0;
            seq_tick <= 1'b0;
         end else if (r_presc == PS_LAST) begin
            r_presc  <= '0;
            seq_tick <= 1'b1;
         end else begin
            r_presc  <= r_presc + PW'(1);
            seq_tick <= 1'b0;
         end
      end
   end

   assign mode = r_mode;

endmodule

// File: tb/tb_tlc_mode_scheduler.sv
// Directed bench for tlc_mode_scheduler: a cycle model derived from the
// behavioural rules is compared every cycle, with literal checkpoints alongside.
module tb_tlc_mode_scheduler;

   localparam int DB = 4;
   localparam int TD = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       brake_pedal_in = 1'b0;
   logic       stalk_left_in = 1'b0;
   logic       stalk_right_in = 1'b0;
   logic       hazard_btn_in = 1'b0;
   logic       brake;
   logic       turn_left;
   logic       turn_right;
   logic       seq_tick;
   logic [1:0] mode;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   tlc_mode_scheduler #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n),
      .brake_pedal_in(brake_pedal_in), .stalk_left_in(stalk_left_in),
      .stalk_right_in(stalk_right_in), .hazard_btn_in(hazard_btn_in),
      .brake(brake), .turn_left(turn_left), .turn_right(turn_right),
      .seq_tick(seq_tick), .mode(mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Model state: raw samples delayed two edges, then per-lane history of
   // synchronised samples; a lane flips once its last DB samples all disagree.
   bit m_d1 [4];
   bit m_d2 [4];
   bit m_hist [4][$];
   bit m_deb [4];
   bit m_haz;
   int m_mode;
   int m_since;
   bit m_tick;

   always @(posedge clk or negedge rst_n) begin
      bit raw [4];
      bit syn;
      bit all_diff;
      bit prev_h;
      int tgt, nm;
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            m_d1[i] = 0; m_d2[i] = 0; m_deb[i] = 0; m_hist[i].delete();
         end
         m_haz = 0; m_mode = 0; m_since = 0; m_tick = 0;
      end else begin
         raw[0] = brake_pedal_in; raw[1] = stalk_left_in;
         raw[2] = stalk_right_in; raw[3] = hazard_btn_in;
         prev_h = m_deb[3];
         for (int i = 0; i < 4; i++) begin
            syn = m_d2[i];
            m_d2[i] = m_d1[i];
            m_d1[i] = raw[i];
            m_hist[i].push_back(syn);
            if (m_hist[i].size() > DB) void'(m_hist[i].pop_front());
            all_diff = (m_hist[i].size() == DB);
            foreach (m_hist[i][k]) if (m_hist[i][k] == m_deb[i]) all_diff = 0;
            if (all_diff) begin
               m_deb[i] = !m_deb[i];
               m_hist[i].delete();
            end
         end
         if (m_deb[3] && !prev_h) m_haz = !m_haz;
         if (m_haz)                     tgt = 3;
         else if (m_deb[1] && !m_deb[2]) tgt = 1;
         else if (m_deb[2] && !m_deb[1]) tgt = 2;
         else                           tgt = 0;
         nm = ((m_mode == 1 && tgt == 2) || (m_mode == 2 && tgt == 1)) ? 0 : tgt;
         if (nm != m_mode) m_since = 0;
         else              m_since++;
         m_mode = nm;
         m_tick = (m_mode != 0) && (m_since > 0) && (m_since % TD == 0);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_brake", int'(brake), int'(m_deb[0]));
         chk("cyc_turn_left", int'(turn_left), int'(m_mode == 1 || m_mode == 3));
         chk("cyc_turn_right", int'(turn_right), int'(m_mode == 2 || m_mode == 3));
         chk("cyc_seq_tick", int'(seq_tick), int'(m_tick));
         chk("cyc_mode", int'(mode), m_mode);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      wait_cyc(3);
      cmp_en = 1'b1;
      chk("rst_brake", int'(brake), 0);
      chk("rst_turns", int'({turn_left, turn_right}), 0);
      chk("rst_tick", int'(seq_tick), 0);
      chk("rst_mode", int'(mode), 0);
      rst_n = 1'b1;
      wait_cyc(2);

      // Left stalk from reset: LEFT after 6 cycles, ticks at 14/22/30
      stalk_left_in = 1'b1;
      wait_cyc(5);  chk("left_c5", int'(turn_left), 0);
      wait_cyc(1);  chk("left_c6", int'(turn_left), 1); chk("left_mode", int'(mode), 1);
      wait_cyc(7);  chk("tick_c13", int'(seq_tick), 0);
      wait_cyc(1);  chk("tick_c14", int'(seq_tick), 1);
      wait_cyc(8);  chk("tick_c22", int'(seq_tick), 1);
      wait_cyc(8);  chk("tick_c30", int'(seq_tick), 1);

      // Short pulses and a 3-on/1-off/3-on glitch train must not register
      stalk_right_in = 1'b1; wait_cyc(3); stalk_right_in = 1'b0; wait_cyc(10);
      chk("pulse3_mode", int'(mode), 1);
      stalk_right_in = 1'b1; wait_cyc(3); stalk_right_in = 1'b0; wait_cyc(1);
      stalk_right_in = 1'b1; wait_cyc(3); stalk_right_in = 1'b0; wait_cyc(10);
      chk("glitch_mode", int'(mode), 1);
      chk("glitch_turn_right", int'(turn_right), 0);

      // LEFT -> RIGHT passes through one IDLE cycle, prescaler restarts
      stalk_left_in = 1'b0; stalk_right_in = 1'b1;
      wait_cyc(5);  chk("sw_c5_mode", int'(mode), 1);
      wait_cyc(1);  chk("sw_c6_mode", int'(mode), 0);
      chk("sw_c6_turns", int'({turn_left, turn_right}), 0);
      wait_cyc(1);  chk("sw_c7_mode", int'(mode), 2); chk("sw_c7_right", int'(turn_right), 1);
      wait_cyc(7);  chk("sw_tick_c14", int'(seq_tick), 0);
      wait_cyc(1);  chk("sw_tick_c15", int'(seq_tick), 1);

      // Hazard press while right held: immediate HAZARD
      hazard_btn_in = 1'b1;
      wait_cyc(5);  chk("haz_c5_mode", int'(mode), 2);
      wait_cyc(1);  chk("haz_c6_mode", int'(mode), 3);
      chk("haz_c6_turns", int'({turn_left, turn_right}), 3);
      wait_cyc(4);  hazard_btn_in = 1'b0; wait_cyc(10);
      chk("haz_release_mode", int'(mode), 3);

      // Brake during HAZARD
      brake_pedal_in = 1'b1;
      wait_cyc(5);  chk("brk_c5", int'(brake), 0);
      wait_cyc(1);  chk("brk_c6", int'(brake), 1); chk("brk_c6_mode", int'(mode), 3);
      chk("brk_c6_turns", int'({turn_left, turn_right}), 3);
      wait_cyc(4);

      // Second press exits straight to RIGHT
      hazard_btn_in = 1'b1;
      wait_cyc(5);  chk("haz2_c5_mode", int'(mode), 3);
      wait_cyc(1);  chk("haz2_c6_mode", int'(mode), 2);
      chk("haz2_c6_turns", int'({turn_left, turn_right}), 1);
      wait_cyc(4);  hazard_btn_in = 1'b0; wait_cyc(10);

      // Both stalks with hazard off is invalid -> IDLE
      stalk_left_in = 1'b1;
      wait_cyc(5);  chk("both_c5_mode", int'(mode), 2);
      wait_cyc(1);  chk("both_c6_mode", int'(mode), 0);
      chk("both_c6_turns", int'({turn_left, turn_right}), 0);
      wait_cyc(4);

      // Brake release and mode change on the same edge
      stalk_right_in = 1'b0; brake_pedal_in = 1'b0;
      wait_cyc(5);  chk("sim_c5_brake", int'(brake), 1); chk("sim_c5_mode", int'(mode), 0);
      wait_cyc(1);  chk("sim_c6_brake", int'(brake), 0); chk("sim_c6_mode", int'(mode), 1);
      wait_cyc(12);

      // Asynchronous reset mid-LEFT, then full re-acquisition
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("arst_turn_left", int'(turn_left), 0);
      chk("arst_mode", int'(mode), 0);
      chk("arst_tick_brake", int'({seq_tick, brake}), 0);
      wait_cyc(2); rst_n = 1'b1;
      wait_cyc(5);  chk("rel_c5_left", int'(turn_left), 0);
      wait_cyc(1);  chk("rel_c6_left", int'(turn_left), 1); chk("rel_c6_mode", int'(mode), 1);
      wait_cyc(10);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tlc_mode_scheduler.md
TLC_MODE_SCHEDULER -- requirements
Module: tlc_mode_scheduler

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a new debounced input level (range 2..255).
REQ-002 Parameter TICK_DIV, default 8: clk cycles per seq_tick period (range 2..65535).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port brake_pedal_in, input, 1: raw brake pedal switch, asynchronous to clk.
REQ-006 Port stalk_left_in, input, 1: raw left turn stalk, asynchronous to clk.
REQ-007 Port stalk_right_in, input, 1: raw right turn stalk, asynchronous to clk.
REQ-008 Port hazard_btn_in, input, 1: raw momentary hazard button, asynchronous to clk.
REQ-009 Port brake, output, 1: brake request to the tail light controller.
REQ-010 Port turn_left, output, 1: left turn request to the tail light controller.
REQ-011 Port turn_right, output, 1: right turn request to the tail light controller.
REQ-012 Port seq_tick, output, 1: one-cycle pulse advancing the tail light sequence step.
REQ-013 Port mode, output, 2: current state; 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer, then a per-input debouncer.
REQ-015 Debounced value SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts that input's counter.
REQ-016 Total input-to-debounced latency SHALL be 2 + DEBOUNCE_CYCLES cycles.
REQ-017 brake SHALL equal debounced brake_pedal_in, registered, independent of mode.
REQ-018 hazard_on SHALL toggle on each debounced rising edge of hazard_btn_in.
REQ-019 Mode priority: hazard_on -> HAZARD; else stalk_left only -> LEFT; else stalk_right only -> RIGHT; else IDLE.
REQ-020 Both stalks debounced high with hazard_on low SHALL select IDLE (invalid combination).
REQ-021 A direct LEFT<->RIGHT change SHALL pass through IDLE for exactly one cycle before entering the new state.
REQ-022 Entry into or exit from HAZARD SHALL be immediate, with no intermediate IDLE cycle.
REQ-023 Outputs per mode: IDLE turn_left=0 turn_right=0; LEFT 1/0; RIGHT 0/1; HAZARD 1/1; all registered.
REQ-024 A tick prescaler SHALL count 0..TICK_DIV-1 and wrap; seq_tick SHALL be 1 in the cycle the count equals TICK_DIV-1.
REQ-025 The prescaler SHALL clear to 0 on every mode change, so the first seq_tick after a change occurs exactly TICK_DIV cycles later.
REQ-026 seq_tick SHALL be held 0 while mode is IDLE.
REQ-027 Simultaneous brake change and mode change SHALL both take effect in the same cycle.

Reset
REQ-028 rst_n low SHALL immediately force brake=0, turn_left=0, turn_right=0, seq_tick=0, mode=00.
REQ-029 Reset SHALL clear the synchronizers, debounced values, debounce counters, hazard_on and the prescaler to 0.
REQ-030 Reset asserted mid-sequence SHALL abort it; after release the block SHALL re-acquire inputs from scratch, with full debounce latency.

Verification
REQ-031 Left stalk held high after reset, defaults -> turn_left=1 and mode=01 at cycle 6 after the stalk rises; seq_tick at cycles 14, 22, 30.
REQ-032 3-cycle pulse on stalk_right_in -> no change on any output.
REQ-033 Left held, then switched to right -> one cycle mode=00 with both turns 0, then mode=10; prescaler restarts.
REQ-034 Hazard pressed while right held -> mode=11, both turns 1; second press -> mode=10 with no IDLE cycle.
REQ-035 Brake pedal pressed during HAZARD -> brake=1 after 6 cycles, turns unchanged; both stalks high with hazard off -> mode=00.
REQ-036 rst_n pulsed low mid-LEFT -> all outputs 0 asynchronously; turn_left returns 6 cycles after release.
